half_word_packer: RTL and testbench
===================================

Name: half_word_packer

Overview:
- Assembles two consecutive 16-bit halfwords into one 32-bit word. It is the inverse of the 32-to-16 half-select path that feeds 16-bit datapath buses from alu_result.
- Sits between 16-bit producers (register-file read port, IR immediate path) and 32-bit consumers (ALU operand latch, 32-bit memory write port).
- Uses a valid/ready handshake on both sides.
- Supports a flush that emits a partial word.

Parameters:
LOW_FIRST, 1, 1 = first accepted halfword goes to out_data[15:0]; 0 = first goes to out_data[31:16]
SIGN_EXT, 0, on flush, missing half is 0 (0) or a copy of the held half's bit 15 (1)
CNT_W, 8, width of completed-word counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_data  input  16  halfword from producer
in_valid  input  1  in_data valid
in_ready  output  1  packer can accept in_data this cycle
flush  input  1  request emission of a held partial word
out_data  output  32  assembled word
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data this cycle
out_partial  output  1  current out word was produced by flush
word_cnt  output  CNT_W  count of words handed off (out_valid && out_ready)

Behaviour:
- Interface fixed: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at clk edge) gives:
  - state = S_EMPTY
  - out_data = 0, out_valid = 0, out_partial = 0, word_cnt = 0
  - holding register = 0
  - rst overrides every other input in that cycle, including mid-word or while out_valid is high; held data is discarded.
- Accept event: in_valid && in_ready. Handoff event: out_valid && out_ready.
- States:
  - S_EMPTY (no half held)
    - in_ready = 1.
    - Accept -> store in_data in hold -> S_HALF.
    - flush is ignored.
  - S_HALF (one half held)
    - in_ready = 1.
    - Accept -> out_data = {in_data, hold} if LOW_FIRST, else {hold, in_data}; out_partial = 0 -> S_FULL.
    - flush without accept -> out_data = hold in the first-half position, other half 0 or sign-filled per SIGN_EXT; out_partial = 1 -> S_FULL.
    - flush with accept in the same cycle: accept wins, full word, flush dropped.
  - S_FULL (word presented)
    - out_valid = 1; in_ready = out_ready (combinational pass-through).
    - Handoff without accept -> S_EMPTY.
    - Handoff with accept -> store in_data in hold -> S_HALF; no bubble.
    - No handoff -> hold state; out_data and out_partial stay stable.
    - flush is ignored.
- Latency:
  - out_valid rises the cycle after the second accept (or after a flush).
  - Sustained throughput is one word per 2 cycles with out_ready held at 1.
- word_cnt increments by 1 on each handoff and wraps modulo 2^CNT_W without saturation.
- out_data holds its last value after a handoff; consumers use it only when out_valid = 1.
- in_data is sampled only on accept; its value at other times is don't-care.

Test Plan:
- Reset, LOW_FIRST=1, out_ready=1; send 0x1234 then 0xABCD on consecutive cycles -> one cycle later out_valid=1, out_data=0xABCD1234, out_partial=0, word_cnt=1 after handoff.
- LOW_FIRST=0; send 0x1234 then 0xABCD -> out_data=0x1234ABCD.
- out_ready=0 after word formed, in_valid held with 0x5555 -> in_ready=0, out_data stable for 5 cycles; raise out_ready -> same-cycle handoff and accept of 0x5555, state S_HALF, no lost halfword.
- Send 0x8001 then flush: SIGN_EXT=0 -> out_data=0x00008001, out_partial=1; SIGN_EXT=1 -> 0xFFFF8001. flush coincident with the second halfword 0x0002 -> out_data=0x00028001, out_partial=0.
- Assert rst while in S_HALF holding 0x7777 -> next cycle in S_EMPTY, out_valid=0, word_cnt=0; then 0x0001, 0x0002 -> 0x00020001 (no stale half).
- CNT_W=8, stream 257 words with out_ready=1 -> word_cnt=1 (wrap); throughput exactly 2 cycles/word.

Source files
------------

// File: rtl/half_word_packer.sv
// Purpose : packs two consecutive 16-bit halfwords into one 32-bit word, with flush for a partial word.
// Latency : out_valid rises the cycle after the second accept (or after flush); 1 word per 2 cycles sustained.
// Backpres: while a word is presented, in_ready follows out_ready so a halfword is taken only alongside a handoff.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   in_data/in_valid/in_ready    16-bit producer side (valid/ready)
//   flush                  emit a held half as a partial word
//   out_data/out_valid/out_ready 32-bit consumer side (valid/ready)
//   out_partial            presented word came from a flush
//   word_cnt               wrapping count of completed handoffs
module half_word_packer #(
   parameter int LOW_FIRST = 1,
   parameter int SIGN_EXT  = 0,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [31:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_partial,
   output logic [CNT_W-1:0] word_cnt
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_HALF  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] hold;
   logic        accept;
   logic        handoff;
   logic [15:0] fill;
   logic [31:0] full_word;
   logic [31:0] part_word;

   assign accept  = in_valid && in_ready;
   assign handoff = out_valid && out_ready;

   // Missing half of a flushed word: zero or a copy of the held half's sign.
   assign fill = (SIGN_EXT != 0) ? {16{hold[15]}} : 16'h0000;

   // The first accepted half (in hold) goes low when LOW_FIRST, else high.
   assign full_word = (LOW_FIRST != 0) ? {in_data, hold} : {hold, in_data};
   assign part_word = (LOW_FIRST != 0) ? {fill, hold}    : {hold, fill};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_EMPTY: begin
            if (accept) state_nxt = S_HALF;
         end
         S_HALF: begin
            // A coincident accept wins over flush; both complete the word.
            if (accept || flush) state_nxt = S_FULL;
         end
         S_FULL: begin
            if (handoff) state_nxt = accept ? S_HALF : S_EMPTY;
         end
         default: state_nxt = S_EMPTY;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_EMPTY: in_ready = 1'b1;
         S_HALF:  in_ready = 1'b1;
         S_FULL: begin
            out_valid = 1'b1;
            // Taking a new half is only safe when the presented word leaves now.
            in_ready  = out_ready;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Datapath: holding register, presented word and handoff counter
   always_ff @(posedge clk) begin
      if (rst) begin
         hold        <= 16'h0000;
         out_data    <= 32'h0000_0000;
         out_partial <= 1'b0;
         word_cnt    <= '0;
      end else begin
         // In S_FULL an accept implies a handoff, so the new half starts a fresh word.
         if (accept && (state == S_EMPTY || state == S_FULL)) begin
            hold <= in_data;
         end
         if (state == S_HALF) begin
            if (accept) begin
               out_data    <= full_word;
               out_partial <= 1'b0;
            end else if (flush) begin
               out_data    <= part_word;
               out_partial <= 1'b1;
            end
         end
         if (handoff) begin
            word_cnt <= word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_half_word_packer.sv
module tb_half_word_packer;

   logic        clk;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        flush;
   logic        out_ready;

   logic        lo_in_ready, hi_in_ready, sx_in_ready;
   logic [31:0] lo_out_data, hi_out_data, sx_out_data;
   logic        lo_out_valid, hi_out_valid, sx_out_valid;
   logic        lo_out_partial, hi_out_partial, sx_out_partial;
   logic [7:0]  lo_word_cnt, hi_word_cnt, sx_word_cnt;

   int checks = 0;
   int errors = 0;

   half_word_packer #(.LOW_FIRST(1), .SIGN_EXT(0), .CNT_W(8)) u_lo (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(lo_in_ready),
      .flush(flush), .out_data(lo_out_data), .out_valid(lo_out_valid), .out_ready(out_ready),
      .out_partial(lo_out_partial), .word_cnt(lo_word_cnt));

   half_word_packer #(.LOW_FIRST(0), .SIGN_EXT(0), .CNT_W(8)) u_hi (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(hi_in_ready),
      .flush(flush), .out_data(hi_out_data), .out_valid(hi_out_valid), .out_ready(out_ready),
      .out_partial(hi_out_partial), .word_cnt(hi_word_cnt));

   half_word_packer #(.LOW_FIRST(1), .SIGN_EXT(1), .CNT_W(8)) u_sx (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(sx_in_ready),
      .flush(flush), .out_data(sx_out_data), .out_valid(sx_out_valid), .out_ready(out_ready),
      .out_partial(sx_out_partial), .word_cnt(sx_word_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One record per cycle: inputs driven that cycle and outputs expected during it.
   typedef struct {
      logic [15:0] d;
      logic        v;
      logic        f;
      logic        r;
      logic        e_ir;
      logic        e_ov;
      logic        e_p;
      logic [31:0] e_lo;
      logic [31:0] e_hi;
      logic [31:0] e_sx;
      logic [7:0]  e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [15:0] d, logic v, logic f, logic r,
                               logic ir, logic ov, logic p,
                               logic [31:0] lo, logic [31:0] hi, logic [31:0] sx,
                               logic [7:0] cnt);
      vec_t t;
      t.d = d; t.v = v; t.f = f; t.r = r;
      t.e_ir = ir; t.e_ov = ov; t.e_p = p;
      t.e_lo = lo; t.e_hi = hi; t.e_sx = sx; t.e_cnt = cnt;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs after the falling edge; outputs settle by #1.
   task automatic cyc(input logic [15:0] d, input logic v, input logic f,
                      input logic r, input logic rs);
      @(negedge clk);
      in_data   = d;
      in_valid  = v;
      flush     = f;
      out_ready = r;
      rst       = rs;
      #1;
   endtask

   initial begin
      int bad;
      int nhand;
      logic        exp_ov;
      logic [15:0] k1, k2;

      rst = 1'b1; in_data = 16'h0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

      // Table of directed cycles (state annotated per row).
      tbl.push_back(mk(16'h1234,1,0,1, 1,0,0, 0,0,0, 0));                                  // EMPTY
      tbl.push_back(mk(16'hABCD,1,0,1, 1,0,0, 0,0,0, 0));                                  // HALF
      tbl.push_back(mk(16'h0000,0,0,1, 1,1,0, 32'hABCD1234,32'h1234ABCD,32'hABCD1234, 0)); // FULL
      tbl.push_back(mk(16'h8001,1,0,1, 1,0,0, 0,0,0, 1));                                  // EMPTY
      tbl.push_back(mk(16'h0000,0,1,1, 1,0,0, 0,0,0, 1));                                  // HALF flush
      tbl.push_back(mk(16'h0000,0,0,0, 0,1,1, 32'h00008001,32'h80010000,32'hFFFF8001, 1)); // FULL stall
      tbl.push_back(mk(16'h0000,0,1,1, 1,1,1, 32'h00008001,32'h80010000,32'hFFFF8001, 1)); // FULL, flush ignored
      tbl.push_back(mk(16'h8001,1,0,1, 1,0,0, 0,0,0, 2));                                  // EMPTY
      tbl.push_back(mk(16'h0002,1,1,1, 1,0,0, 0,0,0, 2));                                  // HALF accept+flush
      tbl.push_back(mk(16'h0000,0,0,1, 1,1,0, 32'h00028001,32'h80010002,32'h00028001, 2)); // FULL
      tbl.push_back(mk(16'h0000,0,1,1, 1,0,0, 0,0,0, 3));                                  // EMPTY flush ignored
      tbl.push_back(mk(16'h1111,1,0,1, 1,0,0, 0,0,0, 3));                                  // EMPTY
      tbl.push_back(mk(16'h2222,1,0,0, 1,0,0, 0,0,0, 3));                                  // HALF
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(16'h5555,1,0,0, 0,1,0, 32'h22221111,32'h11112222,32'h22221111, 3)); // FULL stall
      tbl.push_back(mk(16'h5555,1,0,1, 1,1,0, 32'h22221111,32'h11112222,32'h22221111, 3)); // handoff+accept
      tbl.push_back(mk(16'h6666,1,0,1, 1,0,0, 0,0,0, 4));                                  // HALF (5555 kept)
      tbl.push_back(mk(16'h0000,0,0,1, 1,1,0, 32'h66665555,32'h55556666,32'h66665555, 4)); // FULL
      tbl.push_back(mk(16'h0000,0,0,1, 1,0,0, 0,0,0, 5));                                  // EMPTY

      // Reset state
      cyc(16'h0, 0, 0, 0, 1);
      cyc(16'h0, 0, 0, 0, 0);
      chk("rst_in_ready",   {31'd0, lo_in_ready},    32'd1);
      chk("rst_out_valid",  {31'd0, lo_out_valid},   32'd0);
      chk("rst_partial",    {31'd0, lo_out_partial}, 32'd0);
      chk("rst_data_lo",    lo_out_data,             32'd0);
      chk("rst_data_hi",    hi_out_data,             32'd0);
      chk("rst_cnt",        {24'd0, lo_word_cnt},    32'd0);

      // Table-driven portion
      foreach (tbl[i]) begin
         cyc(tbl[i].d, tbl[i].v, tbl[i].f, tbl[i].r, 0);
         chk($sformatf("row%0d_in_ready", i),    {31'd0, lo_in_ready},  {31'd0, tbl[i].e_ir});
         chk($sformatf("row%0d_in_ready_hi", i), {31'd0, hi_in_ready},  {31'd0, tbl[i].e_ir});
         chk($sformatf("row%0d_out_valid", i),   {31'd0, lo_out_valid}, {31'd0, tbl[i].e_ov});
         chk($sformatf("row%0d_cnt", i),         {24'd0, lo_word_cnt},  {24'd0, tbl[i].e_cnt});
         if (tbl[i].e_ov) begin
            chk($sformatf("row%0d_data_lo", i), lo_out_data, tbl[i].e_lo);
            chk($sformatf("row%0d_data_hi", i), hi_out_data, tbl[i].e_hi);
            chk($sformatf("row%0d_data_sx", i), sx_out_data, tbl[i].e_sx);
            chk($sformatf("row%0d_partial", i),    {31'd0, lo_out_partial}, {31'd0, tbl[i].e_p});
            chk($sformatf("row%0d_partial_sx", i), {31'd0, sx_out_partial}, {31'd0, tbl[i].e_p});
         end
      end

      // Reset while holding a half discards it.
      cyc(16'h7777, 1, 0, 1, 0);
      cyc(16'h9999, 1, 0, 1, 1);
      cyc(16'h0001, 1, 0, 1, 0);
      chk("rsthalf_out_valid", {31'd0, lo_out_valid}, 32'd0);
      chk("rsthalf_in_ready",  {31'd0, lo_in_ready},  32'd1);
      chk("rsthalf_cnt",       {24'd0, lo_word_cnt},  32'd0);
      chk("rsthalf_data",      lo_out_data,           32'd0);
      cyc(16'h0002, 1, 0, 0, 0);
      cyc(16'h0000, 0, 0, 0, 0);
      chk("rsthalf_word_valid", {31'd0, lo_out_valid}, 32'd1);
      chk("rsthalf_word_lo",    lo_out_data, 32'h00020001);
      chk("rsthalf_word_hi",    hi_out_data, 32'h00010002);

      // Reset while a word is presented drops it.
      cyc(16'h0000, 0, 0, 0, 1);
      cyc(16'h0000, 0, 0, 0, 0);
      chk("rstfull_out_valid", {31'd0, lo_out_valid}, 32'd0);
      chk("rstfull_cnt",       {24'd0, lo_word_cnt},  32'd0);

      // Stream 257 words back to back: handoff every 2nd cycle, counter wraps to 1.
      bad = 0;
      nhand = 0;
      for (int k = 0; k <= 514; k++) begin
         cyc(16'(k), (k <= 513), 0, 1, 0);
         exp_ov = (k >= 2) && (k % 2 == 0);
         if (lo_out_valid !== exp_ov) bad++;
         if (lo_out_valid === 1'b1) nhand++;
         if (exp_ov) begin
            k1 = 16'(k - 1);
            k2 = 16'(k - 2);
            if (lo_out_data !== {k1, k2}) bad++;
         end
      end
      cyc(16'h0000, 0, 0, 1, 0);
      chk("stream_pattern_errs", bad,   0);
      chk("stream_handoffs",     nhand, 257);
      chk("stream_cnt_wrap",     {24'd0, lo_word_cnt}, 32'd1);
      chk("stream_cnt_wrap_hi",  {24'd0, hi_word_cnt}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
